// File: rtl/icu_pkg.sv
// Shared types and instruction-word layout for the 1-bit instruction control unit.
package icu_pkg;

   // 4-bit opcode, in the order of the instruction set table
   typedef enum logic [3:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } opcode_e;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_e;

   // Instruction word is {opcode, operand}; the opcode sits directly above
   // the ADDR_W-bit operand, so its LSB position equals ADDR_W.
   localparam int OPC_W       = 4;
   localparam int OPERAND_LSB = 0;

   // Opcodes that drive ram_read while executing.
   function automatic logic reads_ram(input opcode_e op);
      logic r;
      r = 1'b0;
      case (op)
         LD, LDC, AND, ANDC, OR, ORC, XNOR, IEN, OEN: r = 1'b1;
         default:                                     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/icu_logic_unit.sv
// Combinational 1-bit logic unit: next RR from opcode, current RR and masked data.
module icu_logic_unit
   import icu_pkg::*;
(
   input  opcode_e op,
   input  logic    rr,
   input  logic    d,
   output logic    rr_next
);

   // Opcodes outside the logic group leave RR unchanged
   always_comb begin
      rr_next = rr;
      case (op)
         LD:      rr_next = d;
         LDC:     rr_next = ~d;
         AND:     rr_next = rr & d;
         ANDC:    rr_next = rr & ~d;
         OR:      rr_next = rr | d;
         ORC:     rr_next = rr | ~d;
         XNOR:    rr_next = ~(rr ^ d);
         default: rr_next = rr;
      endcase
   end

endmodule

// File: rtl/icu_core.sv
// Instruction control unit: fetch/execute sequencer, program counter, result
// register, I/O enable flags, skip flag and RAM/strobe decode.
//
// state | meaning
// ------+------------------------------------------------------------
// FETCH | pc stable on ROM; instruction word captured into IR at edge
// EXEC  | IR decoded; RAM controls/strobes driven; RR/flags/pc update
module icu_core
   import icu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int PC_W   = 8
)
(
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   pc,
   input  logic [ADDR_W+3:0] prog_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_read,
   output logic              ram_write,
   output logic              ram_wdata,
   input  logic              ram_rdata,
   output logic              rr,
   output logic              jmp_o,
   output logic              rtn_o,
   output logic              flag0_o,
   output logic              flagf_o
);

   localparam int OPC_LSB = ADDR_W;

   state_e              state_q;
   state_e              state_d;
   logic [ADDR_W+3:0]   ir_q;
   logic [PC_W-1:0]     pc_q;
   logic                rr_q;
   logic                ien_q;
   logic                oen_q;
   logic                skip_q;

   opcode_e             op;
   logic [ADDR_W-1:0]   operand;
   logic [PC_W-1:0]     jmp_target;
   logic                d_masked;
   logic                rr_next;
   logic                exec_live;

   assign op        = opcode_e'(ir_q[OPC_LSB +: OPC_W]);
   assign operand   = ir_q[OPERAND_LSB +: ADDR_W];
   assign d_masked  = ram_rdata & ien_q;
   // A skipped instruction and an instruction aborted by rst do nothing visible
   assign exec_live = (state_q == EXEC) && !skip_q && !rst;

   generate
      if (PC_W <= ADDR_W) begin : g_tgt_slice
         assign jmp_target = operand[PC_W-1:0];
      end else begin : g_tgt_ext
         assign jmp_target = {{(PC_W-ADDR_W){1'b0}}, operand};
      end
   endgenerate

   icu_logic_unit u_logic (
      .op      (op),
      .rr      (rr_q),
      .d       (d_masked),
      .rr_next (rr_next)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: strict alternation, every instruction is two cycles
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = EXEC;
         EXEC:    state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // FSM outputs: RAM controls and strobes decoded from IR during a live EXEC
   always_comb begin
      ram_read  = 1'b0;
      ram_write = 1'b0;
      ram_wdata = 1'b0;
      jmp_o     = 1'b0;
      rtn_o     = 1'b0;
      flag0_o   = 1'b0;
      flagf_o   = 1'b0;
      if (exec_live) begin
         ram_read = reads_ram(op);
         case (op)
            STO: begin
               ram_write = oen_q;
               ram_wdata = oen_q & rr_q;
            end
            STOC: begin
               ram_write = oen_q;
               ram_wdata = oen_q & ~rr_q;
            end
            JMP:     jmp_o   = 1'b1;
            RTN:     rtn_o   = 1'b1;
            NOPO:    flag0_o = 1'b1;
            NOPF:    flagf_o = 1'b1;
            default: ;
         endcase
      end
   end

   // Instruction register, program counter and architectural flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q   <= '0;
         pc_q   <= '0;
         rr_q   <= 1'b0;
         ien_q  <= 1'b0;
         oen_q  <= 1'b0;
         skip_q <= 1'b0;
      end else if (state_q == FETCH) begin
         ir_q <= prog_data;
      end else begin
         pc_q   <= pc_q + PC_W'(1);
         skip_q <= 1'b0;
         if (!skip_q) begin
            rr_q <= rr_next;
            case (op)
               IEN:     ien_q  <= ram_rdata;
               OEN:     oen_q  <= ram_rdata;
               JMP:     pc_q   <= jmp_target;
               RTN:     skip_q <= 1'b1;
               SKZ:     skip_q <= ~rr_q;
               default: ;
            endcase
         end
      end
   end

   assign pc          = pc_q;
   assign rr          = rr_q;
   // IR keeps the last executed operand through FETCH, so the address holds
   assign ram_address = operand;

endmodule

// File: tb/tb_icu_core.sv
// Bench for icu_core: exhaustive logic-unit table, directed program sequences
// and a random program checked against an instruction-level reference model.
module tb_icu_core;
   import icu_pkg::*;

   localparam int ADDR_W = 8;
   localparam int PC_W   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [PC_W-1:0]   pc;
   logic [ADDR_W+3:0] prog_data;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_read, ram_write, ram_wdata, ram_rdata;
   logic              rr, jmp_o, rtn_o, flag0_o, flagf_o;
   logic [6:0]        ctl;

   logic [11:0] rom [256];
   logic        ram [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   icu_core #(.ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst), .pc(pc), .prog_data(prog_data),
      .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rr(rr),
      .jmp_o(jmp_o), .rtn_o(rtn_o), .flag0_o(flag0_o), .flagf_o(flagf_o)
   );

   // stand-alone logic unit for the exhaustive table
   opcode_e lu_op;
   logic    lu_rr, lu_d, lu_next;
   icu_logic_unit u_lu (.op(lu_op), .rr(lu_rr), .d(lu_d), .rr_next(lu_next));

   assign prog_data = rom[pc];
   assign ram_rdata = ram_read ? ram[ram_address] : 1'b0;
   assign ctl = {ram_read, ram_write, ram_wdata, jmp_o, rtn_o, flag0_o, flagf_o};

   always @(posedge clk) if (ram_write) ram[ram_address] <= ram_wdata;

   // reference model state (instruction level)
   logic [7:0] m_pc;
   logic       m_rr, m_ien, m_oen, m_skip;
   logic [7:0] m_addr;
   logic       mram [256];
   logic       last_wr, last_wdata, last_jmp, last_rtn, last_f0, last_ff;
   logic [7:0] last_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'd0; m_rr = 1'b0; m_ien = 1'b0; m_oen = 1'b0; m_skip = 1'b0; m_addr = 8'd0;
   endtask

   // rst already high, called just after a rising edge; holds it for 3 edges
   task automatic hold_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_rr", 32'(rr), 32'd0);
      chk("rst_ctl", 32'(ctl), 32'd0);
      chk("rst_addr", 32'(ram_address), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic do_fetch();
      @(negedge clk);
      chk("fetch_pc", 32'(pc), 32'(m_pc));
      chk("fetch_ctl", 32'(ctl), 32'd0);
      chk("fetch_addr", 32'(ram_address), 32'(m_addr));
      chk("fetch_rr", 32'(rr), 32'(m_rr));
      @(posedge clk); #1;
   endtask

   task automatic do_exec();
      logic [11:0] ins;
      logic [3:0]  op;
      logic [7:0]  opd, npc, a_pc, a_addr;
      logic [6:0]  e, a_ctl;
      logic        d, a_rr, n_rr, n_ien, n_oen, n_skip;
      @(negedge clk);
      a_ctl = ctl; a_pc = pc; a_addr = ram_address; a_rr = rr;
      ins = rom[m_pc]; op = ins[11:8]; opd = ins[7:0];
      e = 7'd0; npc = m_pc + 8'd1; d = mram[opd] & m_ien;
      n_rr = m_rr; n_ien = m_ien; n_oen = m_oen; n_skip = 1'b0;
      if (!m_skip) begin
         case (op)
            4'h0: e[1] = 1'b1;
            4'h1: begin e[6] = 1'b1; n_rr = d; end
            4'h2: begin e[6] = 1'b1; n_rr = !d; end
            4'h3: begin e[6] = 1'b1; n_rr = m_rr && d; end
            4'h4: begin e[6] = 1'b1; n_rr = m_rr && !d; end
            4'h5: begin e[6] = 1'b1; n_rr = m_rr || d; end
            4'h6: begin e[6] = 1'b1; n_rr = m_rr || !d; end
            4'h7: begin e[6] = 1'b1; n_rr = (m_rr == d); end
            4'h8: if (m_oen) begin e[5] = 1'b1; e[4] = m_rr; mram[opd] = m_rr; end
            4'h9: if (m_oen) begin e[5] = 1'b1; e[4] = !m_rr; mram[opd] = !m_rr; end
            4'hA: begin e[6] = 1'b1; n_ien = mram[opd]; end
            4'hB: begin e[6] = 1'b1; n_oen = mram[opd]; end
            4'hC: begin e[3] = 1'b1; npc = opd; end
            4'hD: begin e[2] = 1'b1; n_skip = 1'b1; end
            4'hE: n_skip = (m_rr == 1'b0);
            default: e[0] = 1'b1;
         endcase
      end
      chk("exec_pc", 32'(a_pc), 32'(m_pc));
      chk("exec_ctl", 32'(a_ctl), 32'(e));
      chk("exec_addr", 32'(a_addr), 32'(opd));
      chk("exec_rr", 32'(a_rr), 32'(m_rr));
      last_wr = a_ctl[5]; last_wdata = a_ctl[4]; last_jmp = a_ctl[3];
      last_rtn = a_ctl[2]; last_f0 = a_ctl[1]; last_ff = a_ctl[0]; last_addr = a_addr;
      m_pc = npc; m_rr = n_rr; m_ien = n_ien; m_oen = n_oen; m_skip = n_skip; m_addr = opd;
      @(posedge clk); #1;
   endtask

   task automatic do_instr();
      do_fetch();
      do_exec();
   endtask

   typedef struct {
      logic [3:0] op;
      logic       rr;
      logic       d;
      logic       exp_rr;
   } lu_vec_t;

   // next-RR truth table per opcode, bit index {rr,d}
   logic [3:0] tt [16] = '{4'b1100, 4'b1010, 4'b0101, 4'b1000,
                           4'b0100, 4'b1110, 4'b1101, 4'b1001,
                           4'b1100, 4'b1100, 4'b1100, 4'b1100,
                           4'b1100, 4'b1100, 4'b1100, 4'b1100};
   lu_vec_t vecs [64];

   initial begin
      for (int i = 0; i < 64; i++) begin
         vecs[i].op = 4'(i >> 2);
         vecs[i].rr = i[1];
         vecs[i].d  = i[0];
         vecs[i].exp_rr = tt[i >> 2][i[1:0]];
      end
      for (int i = 0; i < 64; i++) begin
         lu_op = opcode_e'(vecs[i].op); lu_rr = vecs[i].rr; lu_d = vecs[i].d;
         #1;
         chk($sformatf("lu_op%0h_rr%0d_d%0d", vecs[i].op, vecs[i].rr, vecs[i].d),
             32'(lu_next), 32'(vecs[i].exp_rr));
      end

      // directed program
      for (int i = 0; i < 256; i++) begin rom[i] = 12'h000; ram[i] = 1'b0; end
      rom[8'h00] = 12'h105; rom[8'h01] = 12'hA01; rom[8'h02] = 12'h105;
      rom[8'h03] = 12'h810; rom[8'h04] = 12'hB01; rom[8'h05] = 12'h910;
      rom[8'h06] = 12'h201; rom[8'h07] = 12'hE00; rom[8'h08] = 12'hC40;
      rom[8'h09] = 12'h101; rom[8'h0A] = 12'hE00; rom[8'h0B] = 12'hC40;
      rom[8'h40] = 12'h000; rom[8'h41] = 12'hF00; rom[8'h42] = 12'hCFE;
      rom[8'hFE] = 12'hD00; rom[8'hFF] = 12'hF00;
      ram[5] = 1'b1; ram[1] = 1'b1;
      for (int i = 0; i < 256; i++) mram[i] = ram[i];

      rst = 1'b1;
      hold_reset();
      do_instr(); chk("mask_ld_rr", 32'(rr), 32'd0);
      do_instr(); do_instr(); chk("unmask_ld_rr", 32'(rr), 32'd1);
      do_instr(); chk("sto_gated", 32'(last_wr), 32'd0);
      do_instr(); do_instr();
      chk("stoc_wr", 32'(last_wr), 32'd1);
      chk("stoc_addr", 32'(last_addr), 32'h10);
      chk("stoc_wdata", 32'(last_wdata), 32'd0);
      do_instr(); do_instr(); do_instr();
      chk("skz_jmp_suppressed", 32'(last_jmp), 32'd0);
      chk("skz_skip_pc", 32'(pc), 32'h09);
      do_instr(); do_instr(); do_instr();
      chk("jmp_pulse", 32'(last_jmp), 32'd1);
      chk("jmp_pc", 32'(pc), 32'h40);
      do_instr(); chk("nopo_flag0", 32'(last_f0), 32'd1);
      do_instr(); chk("nopf_flagf", 32'(last_ff), 32'd1);
      do_instr(); do_instr(); chk("rtn_pulse", 32'(last_rtn), 32'd1);
      do_instr(); chk("rtn_skip_ff", 32'(last_ff), 32'd0);
      chk("wrap_pc", 32'(pc), 32'h00);

      // reset during a live store aborts it
      do_instr(); do_instr(); do_instr();
      do_fetch();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_abort_wr", 32'(ram_write), 32'd0);
      hold_reset();
      chk("rst_abort_ram", 32'(ram[8'h10]), 32'd0);
      do_instr(); chk("post_rst_ien", 32'(rr), 32'd0);
      do_instr(); do_instr(); do_instr();
      chk("post_rst_oen", 32'(last_wr), 32'd0);

      // random program against the model
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [3:0] rop;
         rop = 4'($urandom_range(0, 15));
         rom[i] = {rop, (rop == 4'hC) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15))};
         ram[i] = 1'($urandom_range(0, 1));
         mram[i] = ram[i];
      end
      @(posedge clk); #1;
      hold_reset();
      for (int n = 0; n < 400; n++) do_instr();
      for (int i = 0; i < 16; i++) chk($sformatf("ram_final_%0d", i), 32'(ram[i]), 32'(mram[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
